// File: rtl/a8_pkg.sv
// Shared constants for the Atari-bus aperture controller: FSM state codes,
// register field offsets, status bit positions and the per-cycle hit class.
package a8_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_MREQ   = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_WWAIT  = 3'd5;
    localparam logic [2:0] ST_WREQ   = 3'd6;
    localparam logic [2:0] ST_HOLD   = 3'd7;

    localparam logic [1:0] OFS_START = 2'd0;
    localparam logic [1:0] OFS_SIZE  = 2'd1;
    localparam logic [1:0] OFS_BANK  = 2'd2;
    localparam logic [1:0] OFS_CTRL  = 2'd3;

    localparam int STAT_LATE_RD = 0;
    localparam int STAT_WP_BLK  = 1;

    typedef enum logic [1:0] {MISS, REG, APER} hit_class_t;

endpackage

// File: rtl/a8_phi2_sync.sv
// Two-flop synchronizer for an asynchronous bus clock, plus single-cycle
// rise/fall pulses taken against a registered copy of the synchronized level.
module a8_phi2_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make the three flops shift as one chain per edge.
            meta   <= async_in;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;
    assign fall = ~sync & sync_d;

endmodule

// File: rtl/a8_aperture_ctrl.sv
// Atari bus controller: aperture register window plus bus-cycle sequencer
// towards the memory arbiter. Define APERTURE_WP_EN for per-aperture write protect.
module a8_aperture_ctrl
    import a8_pkg::*;
#(
    parameter int          NUM_APERTURES = 4,
    parameter logic [15:0] REG_BASE      = 16'hD604,
    parameter int          SETTLE_CYCLES = 40,
    parameter int          HOLD_CYCLES   = 4
) (
    input  logic        clk200,
    input  logic        a8_rst_n,
    input  logic        a8_clk,
    input  logic [15:0] a8_addr,
    input  logic        a8_rw_n,
    input  logic [7:0]  a8_data_in,
    output logic [7:0]  a8_data_out,
    output logic        a8_data_oe,
    output logic        a8_extsel_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata
);

    localparam int          SCW        = $clog2(SETTLE_CYCLES + 1);
    localparam int          HCW        = $clog2(HOLD_CYCLES + 2);
    localparam logic [15:0] STATUS_OFS = 16'(4 * NUM_APERTURES);

    logic [7:0]               ap_start [NUM_APERTURES];
    logic [7:0]               ap_size  [NUM_APERTURES];
    logic [7:0]               ap_bank  [NUM_APERTURES];
    logic [NUM_APERTURES-1:0] ap_wp;
    logic [1:0]               status;

    logic [2:0]     state;
    logic [SCW-1:0] settle_cnt;
    logic [HCW-1:0] fall_cnt;
    logic           fell;
    logic [15:0]    ofs_q;
    hit_class_t     cls_q;
    logic           wp_q;
    logic [7:0]     din_d1, din_d2;

    logic phi2_rise, phi2_fall;

    a8_phi2_sync u_sync (
        .clk      (clk200),
        .rst_n    (a8_rst_n),
        .async_in (a8_clk),
        .rise     (phi2_rise),
        .fall     (phi2_fall)
    );

    logic [15:0] reg_ofs;
    logic [7:0]  page;
    logic [7:0]  reg_rdata;
    logic [7:0]  hit_start, hit_bank;
    logic        hit_wp;
    logic [23:0] aper_addr;
    hit_class_t  cls;
    logic        release_now;

    assign reg_ofs     = a8_addr - REG_BASE;
    assign page        = a8_addr[15:8];
    assign aper_addr   = {hit_bank, page - hit_start, a8_addr[7:0]};
    assign release_now = fell && (fall_cnt == HCW'(HOLD_CYCLES));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        reg_rdata = 8'h00;
        hit_start = 8'h00;
        hit_bank  = 8'h00;
        hit_wp    = 1'b0;
        cls       = MISS;
        if (reg_ofs == STATUS_OFS) reg_rdata = {6'b0, status};
        for (int k = 0; k < NUM_APERTURES; k++) begin
            if (reg_ofs[15:2] == 14'(k)) begin
                case (reg_ofs[1:0])
                    OFS_START: reg_rdata = ap_start[k];
                    OFS_SIZE:  reg_rdata = ap_size[k];
                    OFS_BANK:  reg_rdata = ap_bank[k];
                    default:   reg_rdata = {7'b0, ap_wp[k]};
                endcase
            end
        end
        // Descending scan so the lowest-index hit is the one left standing.
        for (int k = NUM_APERTURES - 1; k >= 0; k--) begin
            if ({1'b0, page} >= {1'b0, ap_start[k]} &&
                {1'b0, page} <  {1'b0, ap_start[k]} + {1'b0, ap_size[k]}) begin
                cls       = APER;
                hit_start = ap_start[k];
                hit_bank  = ap_bank[k];
                hit_wp    = ap_wp[k];
            end
        end
        if (reg_ofs <= STATUS_OFS) cls = REG;
    end

`ifndef APERTURE_WP_EN
    assign ap_wp = '0;
`endif

    always_ff @(posedge clk200 or negedge a8_rst_n) begin
        if (!a8_rst_n) begin
            // NOTE: the aperture registers are plain flops, so they reset like any other state.
            for (int k = 0; k < NUM_APERTURES; k++) begin
                ap_start[k] <= 8'h00;
                ap_size[k]  <= 8'h00;
                ap_bank[k]  <= 8'h00;
            end
`ifdef APERTURE_WP_EN
            ap_wp <= '0;
`endif
            status      <= 2'b00;
            state       <= ST_IDLE;
            settle_cnt  <= '0;
            fall_cnt    <= '0;
            fell        <= 1'b0;
            ofs_q       <= 16'h0000;
            cls_q       <= MISS;
            wp_q        <= 1'b0;
            din_d1      <= 8'h00;
            din_d2      <= 8'h00;
            a8_data_out <= 8'h00;
            a8_data_oe  <= 1'b0;
            a8_extsel_n <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 24'h000000;
            mem_wdata   <= 8'h00;
        end else begin
            din_d1 <= a8_data_in;
            din_d2 <= din_d1;

            if (phi2_fall) begin
                fell     <= 1'b1;
                fall_cnt <= HCW'(1);
            end else if (fell && fall_cnt <= HCW'(HOLD_CYCLES)) begin
                fall_cnt <= fall_cnt + 1'b1;
            end

            // Bus-side release runs off the fall timer, independent of the memory ack.
            if (release_now && state != ST_DRAIN) begin
                a8_extsel_n <= 1'b1;
                a8_data_oe  <= 1'b0;
            end

            case (state)
                ST_IDLE: if (phi2_rise) begin
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                    fell       <= 1'b0;
                    fall_cnt   <= '0;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SCW'(SETTLE_CYCLES - 1)) state <= ST_DECODE;
                    else settle_cnt <= settle_cnt + 1'b1;
                end
                ST_DECODE: begin
                    ofs_q <= reg_ofs;
                    cls_q <= cls;
                    wp_q  <= hit_wp;
                    if (cls == MISS) begin
                        state <= ST_IDLE;
                    end else begin
                        a8_extsel_n <= 1'b0;
                        if (cls == APER) mem_addr <= aper_addr;
                        if (!a8_rw_n) begin
                            state <= ST_WWAIT;
                        end else if (cls == REG) begin
                            a8_data_out <= reg_rdata;
                            a8_data_oe  <= 1'b1;
                            state       <= ST_HOLD;
                        end else begin
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            state   <= ST_MREQ;
                        end
                    end
                end
                ST_MREQ: begin
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        a8_data_out <= mem_rdata;
                        a8_data_oe  <= 1'b1;
                        state       <= ST_HOLD;
                    end else if (phi2_fall) begin
                        status[STAT_LATE_RD] <= 1'b1;
                        state                <= ST_DRAIN;
                    end
                end
                ST_DRAIN: if (mem_ack) begin
                    mem_req     <= 1'b0;
                    a8_extsel_n <= 1'b1;
                    state       <= ST_IDLE;
                end
                ST_WWAIT: if (phi2_fall) begin
                    if (cls_q == REG) begin
                        for (int k = 0; k < NUM_APERTURES; k++) begin
                            if (ofs_q[15:2] == 14'(k)) begin
                                case (ofs_q[1:0])
                                    OFS_START: ap_start[k] <= din_d2;
                                    OFS_SIZE:  ap_size[k]  <= din_d2;
                                    OFS_BANK:  ap_bank[k]  <= din_d2;
                                    default: begin
`ifdef APERTURE_WP_EN
                                        ap_wp[k] <= din_d2[0];
`endif
                                    end
                                endcase
                            end
                        end
                        if (ofs_q == STATUS_OFS) begin
                            if (din_d2[STAT_LATE_RD]) status[STAT_LATE_RD] <= 1'b0;
`ifdef APERTURE_WP_EN
                            if (din_d2[STAT_WP_BLK]) status[STAT_WP_BLK] <= 1'b0;
`endif
                        end
                        state <= ST_HOLD;
                    end else if (wp_q) begin
`ifdef APERTURE_WP_EN
                        status[STAT_WP_BLK] <= 1'b1;
`endif
                        state <= ST_HOLD;
                    end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= din_d2;
                        state     <= ST_WREQ;
                    end
                end
                ST_WREQ: if (mem_ack) begin
                    mem_req <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: if (release_now) state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a8_aperture_ctrl.sv
// Self-checking bench for a8_aperture_ctrl: directed scenarios plus a randomized
// run against a behavioural register/aperture model.
module tb_a8_aperture_ctrl;

    localparam int HIGH_CYC = 70;
    localparam int LOW_CYC  = 40;

    logic        clk200 = 1'b0;
    logic        a8_rst_n = 1'b0;
    logic        a8_clk = 1'b0;
    logic [15:0] a8_addr = 16'h0000;
    logic        a8_rw_n = 1'b1;
    logic [7:0]  a8_data_in = 8'h00;
    logic [7:0]  a8_data_out;
    logic        a8_data_oe;
    logic        a8_extsel_n;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;

    a8_aperture_ctrl dut (
        .clk200      (clk200),
        .a8_rst_n    (a8_rst_n),
        .a8_clk      (a8_clk),
        .a8_addr     (a8_addr),
        .a8_rw_n     (a8_rw_n),
        .a8_data_in  (a8_data_in),
        .a8_data_out (a8_data_out),
        .a8_data_oe  (a8_data_oe),
        .a8_extsel_n (a8_extsel_n),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    initial forever #5 clk200 = ~clk200;

    int errors = 0;
    int checks = 0;

    // Memory-side responder state
    int          ack_delay = 3;
    bit          ack_withhold = 1'b0;
    logic [7:0]  resp_data = 8'h00;
    int          req_count = 0;
    int          unstable = 0;
    bit          in_req = 1'b0;
    int          wait_cnt = 0;
    logic [23:0] rec_addr = 24'h0;
    logic        rec_we = 1'b0;
    logic [7:0]  rec_wdata = 8'h0;

    always @(negedge clk200) begin
        if (!a8_rst_n) begin
            mem_ack = 1'b0;
            in_req  = 1'b0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (!in_req) begin
                in_req    = 1'b1;
                wait_cnt  = 0;
                req_count = req_count + 1;
                rec_addr  = mem_addr;
                rec_we    = mem_we;
                rec_wdata = mem_wdata;
            end else if (mem_addr !== rec_addr || mem_we !== rec_we || mem_wdata !== rec_wdata) begin
                unstable = unstable + 1;
            end
            wait_cnt = wait_cnt + 1;
            if (!ack_withhold && wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = resp_data;
                in_req    = 1'b0;
            end
        end
    end

    // Per-bus-cycle observations
    bit         obs_claimed, obs_oe_seen, obs_oe_fall2, obs_oe_end, obs_ext_end;
    logic [7:0] obs_data;
    int         obs_reqs;

    // Behavioural model: register file contents and expected outcome of the last access
    logic [7:0]  m_start [4];
    logic [7:0]  m_size  [4];
    logic [7:0]  m_bank  [4];
    logic [7:0]  m_status;
    int          exp_cls;     // 0 = miss, 1 = register, 2 = aperture
    logic [23:0] exp_maddr;
    logic [7:0]  exp_rval;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_start[k] = 8'h00;
            m_size[k]  = 8'h00;
            m_bank[k]  = 8'h00;
        end
        m_status = 8'h00;
    endtask

    task automatic model_eval(input logic [15:0] addr);
        int page, ofs;
        exp_cls = 0; exp_maddr = 24'h0; exp_rval = 8'h00;
        page = int'(addr) / 256;
        if (addr >= 16'hD604 && addr <= 16'hD614) begin
            exp_cls = 1;
            ofs = int'(addr) - 'hD604;
            if (ofs == 16) exp_rval = m_status;
            else if (ofs % 4 == 0) exp_rval = m_start[ofs / 4];
            else if (ofs % 4 == 1) exp_rval = m_size[ofs / 4];
            else if (ofs % 4 == 2) exp_rval = m_bank[ofs / 4];
            else exp_rval = 8'h00;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (exp_cls == 0 && page >= int'(m_start[k]) &&
                    page < int'(m_start[k]) + int'(m_size[k])) begin
                    exp_cls = 2;
                    exp_maddr = 24'(int'(m_bank[k]) * 65536 + (page - int'(m_start[k])) * 256 + int'(addr) % 256);
                end
            end
        end
    endtask

    task automatic model_write(input logic [15:0] addr, input logic [7:0] data);
        int ofs;
        if (addr >= 16'hD604 && addr <= 16'hD614) begin
            ofs = int'(addr) - 'hD604;
            if (ofs == 16) begin
                if (data[0]) m_status[0] = 1'b0;
            end else if (ofs % 4 == 0) m_start[ofs / 4] = data;
            else if (ofs % 4 == 1) m_size[ofs / 4] = data;
            else if (ofs % 4 == 2) m_bank[ofs / 4] = data;
        end
    endtask

    task automatic bus_cycle(input logic [15:0] addr, input bit rw_n, input logic [7:0] wdata);
        int reqs0;
        reqs0 = req_count;
        obs_claimed = 1'b0; obs_oe_seen = 1'b0; obs_data = 8'h00; obs_oe_fall2 = 1'b0;
        @(negedge clk200);
        a8_addr = addr; a8_rw_n = rw_n; a8_data_in = wdata; a8_clk = 1'b1;
        for (int i = 0; i < HIGH_CYC; i++) begin
            @(negedge clk200);
            if (!a8_extsel_n) obs_claimed = 1'b1;
            if (a8_data_oe) begin obs_oe_seen = 1'b1; obs_data = a8_data_out; end
        end
        a8_clk = 1'b0;
        for (int i = 0; i < LOW_CYC; i++) begin
            @(negedge clk200);
            if (!a8_extsel_n) obs_claimed = 1'b1;
            if (a8_data_oe) begin obs_oe_seen = 1'b1; obs_data = a8_data_out; end
            if (i == 1) obs_oe_fall2 = a8_data_oe;
        end
        obs_oe_end = a8_data_oe; obs_ext_end = a8_extsel_n;
        obs_reqs = req_count - reqs0;
        a8_rw_n = 1'b1;
    endtask

    task automatic access(input logic [15:0] addr, input bit rw_n, input logic [7:0] wdata);
        model_eval(addr);
        bus_cycle(addr, rw_n, wdata);
        if (!rw_n) model_write(addr, wdata);
    endtask

    task automatic test_reset();
        checks++; if (a8_extsel_n !== 1'b1) begin errors++; $display("FAIL reset_extsel_n: got %b want 1", a8_extsel_n); end
        checks++; if (a8_data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", a8_data_oe); end
        checks++; if (a8_data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", a8_data_out); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 24'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 000000", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
    endtask

    task automatic test_reg_rw();
        access(16'hD604, 1'b0, 8'h20);
        checks++; if (obs_claimed !== 1'b1 || obs_reqs !== 0) begin errors++; $display("FAIL regw_start: claimed=%b reqs=%0d want 1/0", obs_claimed, obs_reqs); end
        access(16'hD605, 1'b0, 8'h10);
        checks++; if (obs_claimed !== 1'b1 || obs_reqs !== 0) begin errors++; $display("FAIL regw_size: claimed=%b reqs=%0d want 1/0", obs_claimed, obs_reqs); end
        access(16'hD604, 1'b1, 8'h00);
        checks++; if (obs_claimed !== 1'b1 || obs_reqs !== 0) begin errors++; $display("FAIL regr_claim: claimed=%b reqs=%0d want 1/0", obs_claimed, obs_reqs); end
        checks++; if (obs_data !== 8'h20) begin errors++; $display("FAIL regr_data: got %h want 20", obs_data); end
        checks++; if (obs_oe_fall2 !== 1'b1) begin errors++; $display("FAIL regr_oe_after_fall: got %b want 1", obs_oe_fall2); end
        checks++; if (obs_oe_end !== 1'b0 || obs_ext_end !== 1'b1) begin errors++; $display("FAIL regr_release: oe=%b extsel_n=%b want 0/1", obs_oe_end, obs_ext_end); end
    endtask

    task automatic test_aper_read();
        access(16'hD606, 1'b0, 8'h01);
        resp_data = 8'hA5; ack_delay = 10;
        access(16'h2345, 1'b1, 8'h00);
        checks++; if (obs_reqs !== 1) begin errors++; $display("FAIL aread_reqs: got %0d want 1", obs_reqs); end
        checks++; if (rec_addr !== 24'h010345 || rec_we !== 1'b0) begin errors++; $display("FAIL aread_req: addr=%h we=%b want 010345/0", rec_addr, rec_we); end
        checks++; if (obs_oe_seen !== 1'b1 || obs_data !== 8'hA5) begin errors++; $display("FAIL aread_data: oe=%b data=%h want 1/a5", obs_oe_seen, obs_data); end
        checks++; if (obs_ext_end !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL aread_end: extsel_n=%b req=%b want 1/0", obs_ext_end, mem_req); end
        ack_delay = 3;
    endtask

    task automatic test_aper_write();
        access(16'h2F7E, 1'b0, 8'h5A);
        checks++; if (obs_claimed !== 1'b1 || obs_reqs !== 1) begin errors++; $display("FAIL awrite_claim: claimed=%b reqs=%0d want 1/1", obs_claimed, obs_reqs); end
        checks++; if (rec_addr !== 24'h010F7E || rec_we !== 1'b1 || rec_wdata !== 8'h5A) begin
            errors++; $display("FAIL awrite_req: addr=%h we=%b wdata=%h want 010f7e/1/5a", rec_addr, rec_we, rec_wdata); end
        checks++; if (obs_ext_end !== 1'b1) begin errors++; $display("FAIL awrite_release: extsel_n=%b want 1", obs_ext_end); end
    endtask

    task automatic test_miss();
        access(16'h3000, 1'b1, 8'h00);
        checks++; if (obs_claimed !== 1'b0 || obs_reqs !== 0) begin errors++; $display("FAIL miss_3000: claimed=%b reqs=%0d want 0/0", obs_claimed, obs_reqs); end
        access(16'h0600, 1'b0, 8'h77);
        checks++; if (obs_claimed !== 1'b0 || obs_reqs !== 0) begin errors++; $display("FAIL miss_0600: claimed=%b reqs=%0d want 0/0", obs_claimed, obs_reqs); end
    endtask

    task automatic test_priority_nowrap();
        access(16'hD608, 1'b0, 8'h28);
        access(16'hD609, 1'b0, 8'h10);
        access(16'hD60A, 1'b0, 8'h02);
        access(16'h2800, 1'b1, 8'h00);
        checks++; if (obs_reqs !== 1 || rec_addr !== 24'h010800) begin errors++; $display("FAIL priority: reqs=%0d addr=%h want 1/010800", obs_reqs, rec_addr); end
        access(16'hD60C, 1'b0, 8'hF0);
        access(16'hD60D, 1'b0, 8'hFF);
        access(16'hD60E, 1'b0, 8'h03);
        access(16'hF512, 1'b1, 8'h00);
        checks++; if (obs_reqs !== 1 || rec_addr !== 24'h030512) begin errors++; $display("FAIL nowrap_hit: reqs=%0d addr=%h want 1/030512", obs_reqs, rec_addr); end
        access(16'h0534, 1'b1, 8'h00);
        checks++; if (obs_claimed !== 1'b0 || obs_reqs !== 0) begin errors++; $display("FAIL nowrap_miss: claimed=%b reqs=%0d want 0/0", obs_claimed, obs_reqs); end
    endtask

    task automatic test_late_ack();
        ack_withhold = 1'b1;
        access(16'h2345, 1'b1, 8'h00);
        checks++; if (obs_oe_seen !== 1'b0) begin errors++; $display("FAIL late_oe: got %b want 0", obs_oe_seen); end
        checks++; if (obs_reqs !== 1 || mem_req !== 1'b1 || obs_ext_end !== 1'b0) begin
            errors++; $display("FAIL late_drain: reqs=%0d req=%b extsel_n=%b want 1/1/0", obs_reqs, mem_req, obs_ext_end); end
        ack_withhold = 1'b0;
        for (int i = 0; i < 30 && a8_extsel_n !== 1'b1; i++) @(negedge clk200);
        checks++; if (a8_extsel_n !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL late_finish: extsel_n=%b req=%b want 1/0", a8_extsel_n, mem_req); end
        m_status[0] = 1'b1;
        access(16'hD614, 1'b1, 8'h00);
        checks++; if (obs_data !== 8'h01) begin errors++; $display("FAIL late_status: got %h want 01", obs_data); end
        access(16'hD614, 1'b0, 8'h01);
        access(16'hD614, 1'b1, 8'h00);
        checks++; if (obs_data !== 8'h00) begin errors++; $display("FAIL status_clear: got %h want 00", obs_data); end
    endtask

    task automatic test_random();
        logic [15:0] addr;
        logic [7:0]  wd;
        bit          rw;
        int          k;
        for (int n = 0; n < 24; n++) begin
            k = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: addr = 16'hD604 + 16'($urandom_range(0, 16));
                1: addr = {m_start[k] + 8'($urandom_range(0, 3)), 8'($urandom)};
                2: addr = 16'($urandom);
                default: addr = {8'($urandom_range(8'hE8, 8'hFF)), 8'($urandom)};
            endcase
            rw = 1'($urandom_range(0, 1));
            wd = 8'($urandom);
            resp_data = 8'($urandom);
            ack_delay = $urandom_range(1, 8);
            access(addr, rw, wd);
            checks++; if (obs_claimed !== (exp_cls != 0)) begin errors++; $display("FAIL rnd_claim %h: got %b want %b", addr, obs_claimed, exp_cls != 0); end
            checks++; if (obs_reqs !== (exp_cls == 2 ? 1 : 0)) begin errors++; $display("FAIL rnd_reqs %h: got %0d want %0d", addr, obs_reqs, exp_cls == 2 ? 1 : 0); end
            if (exp_cls == 1 && rw) begin
                checks++; if (obs_data !== exp_rval) begin errors++; $display("FAIL rnd_regread %h: got %h want %h", addr, obs_data, exp_rval); end
            end else if (exp_cls == 2) begin
                checks++; if (rec_addr !== exp_maddr || rec_we !== !rw) begin errors++; $display("FAIL rnd_memreq %h: addr=%h we=%b want %h/%b", addr, rec_addr, rec_we, exp_maddr, !rw); end
                checks++; if (rw ? (obs_data !== resp_data) : (rec_wdata !== wd)) begin
                    errors++; $display("FAIL rnd_memdata %h: rd=%h wd=%h want %h", addr, obs_data, rec_wdata, rw ? resp_data : wd); end
            end
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL req_stability: got %0d unstable cycles want 0", unstable); end
        ack_delay = 3;
    endtask

    task automatic test_reset_mid();
        int waited;
        ack_withhold = 1'b1;
        @(negedge clk200);
        a8_addr = 16'h2345; a8_rw_n = 1'b1; a8_clk = 1'b1;
        waited = 0;
        while (mem_req !== 1'b1 && waited < 200) begin @(negedge clk200); waited++; end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_timeout: req=%b want 1", mem_req); end
        #2 a8_rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || a8_extsel_n !== 1'b1 || a8_data_oe !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs: req=%b extsel_n=%b oe=%b want 0/1/0", mem_req, a8_extsel_n, a8_data_oe); end
        a8_clk = 1'b0;
        repeat (5) @(negedge clk200);
        a8_rst_n = 1'b1;
        ack_withhold = 1'b0;
        model_reset();
        access(16'hD604, 1'b1, 8'h00);
        checks++; if (obs_data !== 8'h00) begin errors++; $display("FAIL rstmid_start0: got %h want 00", obs_data); end
        access(16'hD606, 1'b1, 8'h00);
        checks++; if (obs_data !== 8'h00) begin errors++; $display("FAIL rstmid_bank0: got %h want 00", obs_data); end
        access(16'hD60D, 1'b1, 8'h00);
        checks++; if (obs_data !== 8'h00) begin errors++; $display("FAIL rstmid_size2: got %h want 00", obs_data); end
        access(16'h2345, 1'b1, 8'h00);
        checks++; if (obs_claimed !== 1'b0 || obs_reqs !== 0) begin errors++; $display("FAIL rstmid_disabled: claimed=%b reqs=%0d want 0/0", obs_claimed, obs_reqs); end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk200);
        test_reset();
        a8_rst_n = 1'b1;
        repeat (3) @(negedge clk200);
        test_reg_rw();
        test_aper_read();
        test_aper_write();
        test_miss();
        test_priority_nowrap();
        test_late_ack();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
